// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types: bus widths, reset/stall polarities, FSM encoding
// and the {pc, inst, valid} record used for both output and pending registers.
package inst_fetch_pkg;

  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  localparam InstBus ZeroWord  = 32'h0000_0000;
  localparam logic   RstEnable = 1'b0;
  localparam logic   Stop      = 1'b1;

  typedef enum logic [1:0] {
    IF_LOOKUP = 2'd0,
    IF_FETCH  = 2'd1,
    IF_HOLD   = 2'd2
  } if_state_e;

  typedef struct packed {
    InstAddrBus pc;
    InstBus     inst;
    logic       valid;
  } fetch_out_t;

  // Width of a cache index for a given power-of-two line count.
  function automatic int unsigned icache_idx_bits(input int unsigned entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line. Combinational
// read (hit + data), single synchronous write port.
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter  int unsigned ENTRIES      = 32,
  localparam int unsigned IcacheIdxBus = icache_idx_bits(ENTRIES),
  localparam int unsigned TagBits      = 30 - IcacheIdxBus
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [IcacheIdxBus-1:0] rd_idx_i,
  input  logic [TagBits-1:0]      rd_tag_i,
  output logic                    hit_o,
  output InstBus                  rd_data_o,
  input  logic                    wr_en_i,
  input  logic [IcacheIdxBus-1:0] wr_idx_i,
  input  logic [TagBits-1:0]      wr_tag_i,
  input  InstBus                  wr_data_i
);

  logic [ENTRIES-1:0] valid_q;
  logic [TagBits-1:0] tag_q  [ENTRIES];
  InstBus             data_q [ENTRIES];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (rst_in == RstEnable) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; the valid bits guard them,
  // which lets the arrays map onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction-fetch stage: cache lookup, byte-serial refill over the
// shared memory port, stall hold and redirect flush.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter InstAddrBus  RESET_PC       = 32'h0,
  parameter int unsigned ICACHE_ENTRIES = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       stall_in,
  input  logic       redirect_in,
  input  InstAddrBus redirect_pc_in,
  output logic       mem_req_out,
  output InstAddrBus mem_addr_out,
  input  logic       mem_gnt_in,
  input  logic [7:0] mem_data_in,
  output InstAddrBus pc_out,
  output InstBus     inst_out,
  output logic       inst_valid_out
);

  localparam int unsigned Idx     = icache_idx_bits(ICACHE_ENTRIES);
  localparam int unsigned TagBits = 30 - Idx;

  if_state_e   state_q, state_d;
  InstAddrBus  fetch_pc_q, fetch_pc_d;
  logic [2:0]  iss_cnt_q, iss_cnt_d;
  logic [2:0]  rcv_cnt_q, rcv_cnt_d;
  logic [23:0] byte_buf_q, byte_buf_d;
  logic        byte_due_q, byte_due_d;
  fetch_out_t  pend_q, pend_d;
  fetch_out_t  out_q, out_d;

  logic       hit;
  InstBus     hit_data;
  logic       fill_done;
  InstBus     fill_word;
  InstAddrBus pc_inc;

  assign pc_inc    = fetch_pc_q + 32'd4;
  assign fill_word = {mem_data_in, byte_buf_q};
  // The 4th byte completes the line unless a redirect squashes it this cycle.
  assign fill_done = (state_q == IF_FETCH) && byte_due_q && (rcv_cnt_q == 3'd3) && !redirect_in;

  inst_fetch_icache #(.ENTRIES(ICACHE_ENTRIES)) u_icache (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd_idx_i  (fetch_pc_q[Idx+1:2]),
    .rd_tag_i  (fetch_pc_q[31:Idx+2]),
    .hit_o     (hit),
    .rd_data_o (hit_data),
    .wr_en_i   (fill_done),
    .wr_idx_i  (fetch_pc_q[Idx+1:2]),
    .wr_tag_i  (fetch_pc_q[31:Idx+2]),
    .wr_data_i (fill_word)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (rst_in == RstEnable) state_q <= IF_LOOKUP;
    else                     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_in) begin
      state_d = IF_LOOKUP;
    end else begin
      case (state_q)
        IF_LOOKUP: if (!hit)               state_d = IF_FETCH;
        IF_FETCH:  if (fill_done)          state_d = (stall_in == Stop) ? IF_HOLD : IF_LOOKUP;
        IF_HOLD:   if (stall_in != Stop)   state_d = IF_LOOKUP;
        default:                           state_d = IF_LOOKUP;
      endcase
    end
  end

  always_comb begin
    mem_req_out  = 1'b0;
    mem_addr_out = ZeroWord;
    if ((state_q == IF_FETCH) && (iss_cnt_q < 3'd4) && !redirect_in) begin
      mem_req_out  = 1'b1;
      mem_addr_out = fetch_pc_q + {29'd0, iss_cnt_q};
    end
  end

  // NOTE: every _d gets a default first, so no path can leave one unassigned
  // and infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    byte_buf_d = byte_buf_q;
    byte_due_d = 1'b0;
    pend_d     = pend_q;
    out_d      = out_q;
    if (stall_in != Stop) out_d.valid = 1'b0;

    if (redirect_in) begin
      fetch_pc_d   = redirect_pc_in;
      iss_cnt_d    = 3'd0;
      rcv_cnt_d    = 3'd0;
      pend_d.valid = 1'b0;
      out_d.valid  = 1'b0;
    end else begin
      case (state_q)
        IF_LOOKUP: begin
          if (!hit) begin
            iss_cnt_d = 3'd0;
            rcv_cnt_d = 3'd0;
          end else if (stall_in != Stop) begin
            out_d      = '{pc: fetch_pc_q, inst: hit_data, valid: 1'b1};
            fetch_pc_d = pc_inc;
          end
        end
        IF_FETCH: begin
          if (mem_req_out && mem_gnt_in) begin
            iss_cnt_d  = iss_cnt_q + 3'd1;
            byte_due_d = 1'b1;
          end
          if (byte_due_q) begin
            rcv_cnt_d = rcv_cnt_q + 3'd1;
            case (rcv_cnt_q)
              3'd0:    byte_buf_d[7:0]   = mem_data_in;
              3'd1:    byte_buf_d[15:8]  = mem_data_in;
              3'd2:    byte_buf_d[23:16] = mem_data_in;
              default: begin
                if (stall_in != Stop) begin
                  out_d      = '{pc: fetch_pc_q, inst: fill_word, valid: 1'b1};
                  fetch_pc_d = pc_inc;
                end else begin
                  pend_d = '{pc: fetch_pc_q, inst: fill_word, valid: 1'b1};
                end
              end
            endcase
          end
        end
        IF_HOLD: begin
          if (stall_in != Stop) begin
            out_d        = pend_q;
            pend_d.valid = 1'b0;
            fetch_pc_d   = pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignment so all of them sample the
  // pre-edge values computed above.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (rst_in == RstEnable) begin
      fetch_pc_q <= RESET_PC;
      iss_cnt_q  <= 3'd0;
      rcv_cnt_q  <= 3'd0;
      byte_buf_q <= '0;
      byte_due_q <= 1'b0;
      pend_q     <= '0;
      out_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      byte_buf_q <= byte_buf_d;
      byte_due_q <= byte_due_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
    end
  end

  assign pc_out         = out_q.pc;
  assign inst_out       = out_q.inst;
  assign inst_valid_out = out_q.valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed timing scenarios plus a randomized run checked
// against a program-order model of the fetched instruction stream.
module tb_inst_fetch;

  logic        clk_in         = 1'b0;
  logic        rst_in         = 1'b0;
  logic        stall_in       = 1'b0;
  logic        redirect_in    = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_gnt_in     = 1'b1;
  logic [7:0]  mem_data_in    = 8'h00;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  inst_fetch #(.RESET_PC(32'h0), .ICACHE_ENTRIES(32)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .stall_in       (stall_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_gnt_in     (mem_gnt_in),
    .mem_data_in    (mem_data_in),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .inst_valid_out (inst_valid_out)
  );

  // Program image: word 0 is addi x0,x0,0 (0x13); the rest is a hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0) return 32'h0000_0013;
    return (w * 32'h9E37_79B1) ^ 32'hA5C3_0F11;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] s;
    s = mem_word(a) >> {a[1:0], 3'b000};
    return s[7:0];
  endfunction

  // One clock: sample the handshake before the edge, return the byte after it.
  // Entered and left at posedge+1.
  task automatic step(output logic fire, output logic [31:0] addr);
    #2;
    fire = mem_req_out && mem_gnt_in;
    addr = mem_addr_out;
    @(posedge clk_in);
    #1;
    mem_data_in = fire ? mem_byte(addr) : 8'($urandom);
  endtask

  task automatic redirect_to(input logic [31:0] pc, output logic fire);
    logic [31:0] addr;
    redirect_in    = 1'b1;
    redirect_pc_in = pc;
    step(fire, addr);
    redirect_in    = 1'b0;
  endtask

  task automatic run_until_valid(input int limit, output int n_steps);
    logic fire;
    logic [31:0] addr;
    n_steps = -1;
    for (int n = 1; n <= limit; n++) begin
      step(fire, addr);
      if (inst_valid_out) begin
        n_steps = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    vectors++;
    if (pc_out !== 32'h0 || inst_out !== 32'h0 || inst_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pc=%h inst=%h v=%b, want 0/0/0", pc_out, inst_out, inst_valid_out);
    end
    vectors++;
    if (mem_req_out !== 1'b0 || mem_addr_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem: got req=%b addr=%h, want 0/0", mem_req_out, mem_addr_out);
    end
  endtask

  task automatic test_first_miss();
    logic fire;
    logic [31:0] addr;
    logic [31:0] addrs[$];
    int got_at;
    got_at = -1;
    rst_in = 1'b1;
    for (int n = 1; n <= 12 && got_at < 0; n++) begin
      step(fire, addr);
      if (fire) addrs.push_back(addr);
      if (inst_valid_out) got_at = n;
    end
    vectors++;
    if (got_at != 6) begin
      miscompares++;
      $display("FAIL miss_latency: got cycle %0d, want 6", got_at);
    end
    vectors++;
    if (addrs.size() != 4) begin
      miscompares++;
      $display("FAIL miss_req_count: got %0d requests, want 4", addrs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (addrs[i] !== 32'(i)) begin
          miscompares++;
          $display("FAIL miss_addr%0d: got %h want %h", i, addrs[i], 32'(i));
        end
      end
    end
    vectors++;
    if (pc_out !== 32'h0 || inst_out !== 32'h13 || inst_valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL first_inst: got pc=%h inst=%h v=%b, want 0/00000013/1", pc_out, inst_out, inst_valid_out);
    end
  endtask

  task automatic test_loop();
    logic fire;
    logic [31:0] addr;
    int n;
    run_until_valid(20, n);
    vectors++;
    if (n < 0 || pc_out !== 32'h4 || inst_out !== mem_word(32'h4)) begin
      miscompares++;
      $display("FAIL loop_fill4: got pc=%h inst=%h after %0d, want pc=4 inst=%h", pc_out, inst_out, n, mem_word(32'h4));
    end
    redirect_to(32'h0, fire);
    vectors++;
    if (inst_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL loop_bubble: got v=%b want 0", inst_valid_out);
    end
    for (int k = 0; k < 2; k++) begin
      step(fire, addr);
      vectors++;
      if (fire !== 1'b0 || inst_valid_out !== 1'b1 || pc_out !== 32'(4 * k) || inst_out !== mem_word(32'(4 * k))) begin
        miscompares++;
        $display("FAIL loop_hit%0d: got req=%b v=%b pc=%h inst=%h, want 0/1/%h/%h",
                 k, fire, inst_valid_out, pc_out, inst_out, 32'(4 * k), mem_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_gnt_withhold();
    logic fire;
    logic [31:0] addr;
    int held, got_at;
    held   = 0;
    got_at = -1;
    redirect_to(32'h300, fire);
    for (int k = 2; k <= 30 && got_at < 0; k++) begin
      mem_gnt_in = !(mem_req_out && mem_addr_out == 32'h302 && held < 3);
      if (!mem_gnt_in) held++;
      step(fire, addr);
      if (inst_valid_out) got_at = k;
    end
    mem_gnt_in = 1'b1;
    vectors++;
    if (held != 3 || got_at != 10) begin
      miscompares++;
      $display("FAIL gnt_withhold_timing: got held=%0d done=%0d, want 3/10", held, got_at);
    end
    vectors++;
    if (pc_out !== 32'h300 || inst_out !== mem_word(32'h300)) begin
      miscompares++;
      $display("FAIL gnt_withhold_inst: got pc=%h inst=%h, want 300/%h", pc_out, inst_out, mem_word(32'h300));
    end
  endtask

  task automatic test_stall_hold();
    logic fire;
    logic [31:0] addr, prev_pc, prev_inst;
    int hold_req;
    hold_req = 0;
    redirect_to(32'h400, fire);
    prev_pc   = pc_out;
    prev_inst = inst_out;
    stall_in  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(fire, addr);
      if (k >= 7 && fire) hold_req++;
    end
    vectors++;
    if (hold_req != 0 || inst_valid_out !== 1'b0 || pc_out !== prev_pc || inst_out !== prev_inst) begin
      miscompares++;
      $display("FAIL stall_hold: got req=%0d v=%b pc=%h inst=%h, want 0/0/%h/%h",
               hold_req, inst_valid_out, pc_out, inst_out, prev_pc, prev_inst);
    end
    stall_in = 1'b0;
    step(fire, addr);
    vectors++;
    if (inst_valid_out !== 1'b1 || pc_out !== 32'h400 || inst_out !== mem_word(32'h400)) begin
      miscompares++;
      $display("FAIL stall_release: got v=%b pc=%h inst=%h, want 1/400/%h",
               inst_valid_out, pc_out, inst_out, mem_word(32'h400));
    end
  endtask

  task automatic test_redirect_mid();
    logic fire;
    logic [31:0] addr;
    int n;
    redirect_to(32'h80, fire);
    repeat (3) step(fire, addr);
    redirect_to(32'h100, fire);
    vectors++;
    if (fire !== 1'b0 || inst_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_flush: got req=%b v=%b, want 0/0", fire, inst_valid_out);
    end
    step(fire, addr);
    step(fire, addr);
    vectors++;
    if (fire !== 1'b1 || addr !== 32'h100) begin
      miscompares++;
      $display("FAIL redirect_restart: got req=%b addr=%h, want 1/100", fire, addr);
    end
    run_until_valid(12, n);
    vectors++;
    if (n < 0 || pc_out !== 32'h100 || inst_out !== mem_word(32'h100)) begin
      miscompares++;
      $display("FAIL redirect_inst: got pc=%h inst=%h, want 100/%h", pc_out, inst_out, mem_word(32'h100));
    end
    redirect_to(32'h80, fire);
    step(fire, addr);
    step(fire, addr);
    vectors++;
    if (fire !== 1'b1 || addr !== 32'h80) begin
      miscompares++;
      $display("FAIL redirect_no_fill: got req=%b addr=%h, want 1/80 (miss)", fire, addr);
    end
    run_until_valid(12, n);
    vectors++;
    if (n < 0 || pc_out !== 32'h80 || inst_out !== mem_word(32'h80)) begin
      miscompares++;
      $display("FAIL refetch_inst: got pc=%h inst=%h, want 80/%h", pc_out, inst_out, mem_word(32'h80));
    end
  endtask

  task automatic test_wrap();
    logic fire;
    int n;
    redirect_to(32'hFFFF_FFFC, fire);
    run_until_valid(20, n);
    vectors++;
    if (n < 0 || pc_out !== 32'hFFFF_FFFC || inst_out !== mem_word(32'hFFFF_FFFC)) begin
      miscompares++;
      $display("FAIL wrap_last: got pc=%h inst=%h, want fffffffc/%h", pc_out, inst_out, mem_word(32'hFFFF_FFFC));
    end
    run_until_valid(20, n);
    vectors++;
    if (n < 0 || pc_out !== 32'h0 || inst_out !== 32'h13) begin
      miscompares++;
      $display("FAIL wrap_next: got pc=%h inst=%h, want 0/00000013", pc_out, inst_out);
    end
  endtask

  task automatic test_reset_midfetch();
    logic fire;
    logic [31:0] addr;
    int n;
    redirect_to(32'h500, fire);
    step(fire, addr);
    #2;
    vectors++;
    if (mem_req_out !== 1'b1) begin
      miscompares++;
      $display("FAIL midfetch_active: got req=%b want 1", mem_req_out);
    end
    rst_in = 1'b0;
    #1;
    vectors++;
    if (mem_req_out !== 1'b0 || mem_addr_out !== 32'h0 || inst_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got req=%b addr=%h v=%b, want 0/0/0", mem_req_out, mem_addr_out, inst_valid_out);
    end
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    step(fire, addr);
    step(fire, addr);
    vectors++;
    if (fire !== 1'b1 || addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_restart: got req=%b addr=%h, want 1/0 (cache cleared)", fire, addr);
    end
    run_until_valid(12, n);
    vectors++;
    if (n < 0 || pc_out !== 32'h0 || inst_out !== 32'h13) begin
      miscompares++;
      $display("FAIL reset_restart_inst: got pc=%h inst=%h, want 0/00000013", pc_out, inst_out);
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0040;
      2:       return 32'h0000_0080;
      3:       return 32'h0000_1F80;
      default: return 32'hFFFF_FFF0;
    endcase
  endfunction

  // Model: instructions leave in program order from the last redirect target;
  // stalled cycles hold the outputs; a redirect always yields a bubble.
  task automatic test_random();
    logic fire, do_redir;
    logic [31:0] addr, tgt, exp_pc, prev_pc, prev_inst;
    logic prev_v;
    int retired;
    retired = 0;
    exp_pc  = pick_target();
    redirect_to(exp_pc, fire);
    prev_pc = pc_out; prev_inst = inst_out; prev_v = inst_valid_out;
    for (int n = 0; n < 1500; n++) begin
      do_redir       = ($urandom_range(0, 99) < 3);
      tgt            = pick_target();
      stall_in       = ($urandom_range(0, 99) < 30);
      mem_gnt_in     = ($urandom_range(0, 99) < 70);
      redirect_in    = do_redir;
      redirect_pc_in = tgt;
      step(fire, addr);
      redirect_in    = 1'b0;
      vectors++;
      if (do_redir) begin
        if (inst_valid_out !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd_redirect n=%0d: got v=%b want 0", n, inst_valid_out);
        end
        exp_pc = tgt;
      end else if (stall_in) begin
        if (pc_out !== prev_pc || inst_out !== prev_inst || inst_valid_out !== prev_v) begin
          miscompares++;
          $display("FAIL rnd_stall n=%0d: got %h/%h/%b want %h/%h/%b",
                   n, pc_out, inst_out, inst_valid_out, prev_pc, prev_inst, prev_v);
        end
      end else if (inst_valid_out) begin
        if (pc_out !== exp_pc || inst_out !== mem_word(exp_pc)) begin
          miscompares++;
          $display("FAIL rnd_inst n=%0d: got pc=%h inst=%h want %h/%h", n, pc_out, inst_out, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        retired++;
      end
      prev_pc = pc_out; prev_inst = inst_out; prev_v = inst_valid_out;
    end
    stall_in   = 1'b0;
    mem_gnt_in = 1'b1;
    vectors++;
    if (retired < 50) begin
      miscompares++;
      $display("FAIL rnd_progress: got %0d instructions, want at least 50", retired);
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_loop();
    test_gnt_withhold();
    test_stall_hold();
    test_redirect_mid();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
